// File: rtl/ramio_bram_responder_if.sv
// ramio bus between the core (master) and the BRAM responder (slave).
interface ramio_bram_responder_if;
    logic        enable;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        misaligned_err;

    modport master (
        output enable, read_type, write_type, address, data_in,
        input  data_out, data_out_ready, busy, misaligned_err
    );

    modport slave (
        input  enable, read_type, write_type, address, data_in,
        output data_out, data_out_ready, busy, misaligned_err
    );
endinterface

// File: rtl/ramio_bram_responder.sv
// ramio bus responder backed by a single-port byte-enabled BRAM with sized, sign-extending reads.
// Optional LED register at LedAddress is enabled by defining RAMIO_LED_IO_EN.
module ramio_bram_responder #(
    parameter int          AddrWidth    = 14,
    parameter int          ReadLatency  = 1,
    parameter int          WriteLatency = 1,
    parameter logic [31:0] LedAddress   = 32'hFFFF_FFFC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ramio_bram_responder_if.slave   bus,
    output logic [3:0]              led
);

    typedef enum logic [1:0] {Idle, Read, Write, Done} state_t;

    typedef struct packed {
        logic [2:0]  read_type;
        logic [1:0]  write_type;
        logic [31:0] address;
        logic [31:0] data_in;
    } req_t;

`ifdef RAMIO_LED_IO_EN
    localparam bit LedEn = 1'b1;
`else
    localparam bit LedEn = 1'b0;
`endif

    state_t      state;
    logic [7:0]  cnt;
    req_t        req_q;
    req_t        cur;
    logic        match;
    logic [31:0] data_out_q;
    logic        misaligned_q;
    logic        is_led;
    logic        ram_we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic [AddrWidth-1:0] word_addr;
    logic [31:0] mem [2**AddrWidth];

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == 2'b10) && lo[0]) || ((size == 2'b11) && (lo != 2'b00));
    endfunction

    function automatic logic [31:0] fmt_read(input logic [31:0] w, input logic [2:0] rt,
                                             input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (rt[1:0])
            2'b01:   return rt[2] ? {{24{b[7]}}, b} : {24'b0, b};
            2'b10:   return rt[2] ? {{16{h[15]}}, h} : {16'b0, h};
            default: return w;
        endcase
    endfunction

    assign cur = '{read_type: bus.read_type, write_type: bus.write_type,
                   address: bus.address, data_in: bus.data_in};
    assign match = bus.enable && (cur == req_q);

    assign word_addr = req_q.address[AddrWidth+1:2];
    assign is_led    = LedEn && (req_q.address[31:2] == LedAddress[31:2]);
    assign ram_we    = (state == Write) && !is_led;
    assign rd_word   = is_led ? {28'b0, led} : mem[word_addr];

    // Handshake outputs are combinational so the initiator sees busy in the request cycle.
    assign bus.busy           = (state == Read) || (state == Write) ||
                                (bus.enable && !((state == Done) && match));
    assign bus.data_out_ready = (state == Done) && match && (req_q.read_type != 3'b000);
    assign bus.data_out       = data_out_q;
    assign bus.misaligned_err = misaligned_q;

    always_comb begin
        be    = 4'b0000;
        wdata = req_q.data_in;
        case (req_q.write_type)
            2'b01: begin
                be    = 4'b0001 << req_q.address[1:0];
                wdata = {4{req_q.data_in[7:0]}};
            end
            2'b10: begin
                be    = req_q.address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req_q.data_in[15:0]}};
            end
            2'b11:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= Idle;
            cnt          <= '0;
            req_q        <= '0;
            data_out_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    cnt <= '0;
                    if (bus.enable && (bus.write_type != 2'b00)) begin
                        req_q <= cur;
                        state <= Write;
                        if (misaligned(bus.write_type, bus.address[1:0])) misaligned_q <= 1'b1;
                    end else if (bus.enable && (bus.read_type != 3'b000)) begin
                        req_q <= cur;
                        state <= Read;
                        if (misaligned(bus.read_type[1:0], bus.address[1:0])) misaligned_q <= 1'b1;
                    end
                end
                Read: begin
                    if (cnt == 8'(ReadLatency - 1)) begin
                        data_out_q <= fmt_read(rd_word, req_q.read_type, req_q.address[1:0]);
                        state      <= Done;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                Write: begin
                    if (cnt == 8'(WriteLatency - 1)) state <= Done;
                    else                              cnt   <= cnt + 8'd1;
                end
                // A changed or dropped request costs one bubble here; capture happens in Idle.
                Done: if (!match) state <= Idle;
                default: state <= Idle;
            endcase
        end
    end

`ifdef RAMIO_LED_IO_EN
    logic [3:0] led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         led_q <= 4'b1111;
        else if ((state == Write) && is_led) led_q <= req_q.data_in[3:0];
    end

    assign led = led_q;
`else
    assign led = 4'b1111;
`endif

endmodule
